// File: rtl/shifter_right_seq.sv
// -----------------------------------------------------------------------------
// shifter_right_seq
//
// Multi-cycle logical right shifter for the ALU shift path. An accepted
// request is shifted one binary stage per clock (1, 2, 4, 8 and then 16 bits),
// with each stage controlled by one bit of the shift amount. Every operation
// takes the same number of cycles, including invalid ones. An invalid
// operation is a wrong op code or an amount of 32 or more, and it returns 0.
//
// Optional feature (macro SHIFTERS_SRA_EN):
//   When the macro is defined, op code SRA is also valid. The fill bit is then
//   latched from dataA[31], which gives sign extension. When the macro is not
//   defined, SRA is an unknown code and the fill is a constant 0.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high reset
//   start   in   1   request; sampled only while idle
//   dataA   in  32   value to shift
//   dataB   in  32   shift amount; bits [31:5] must be 0 for a valid result
//   Signal  in   6   op code
//   dataOut out 32   registered result; holds until the next completion
//   busy    out  1   high while an operation is in progress
//   done    out  1   one-cycle pulse when dataOut updates
// -----------------------------------------------------------------------------
module shifter_right_seq #(
    parameter int         DATA_W  = 32,
    parameter int         SHAMT_W = 5,
    parameter logic [5:0] SRL     = 6'b000010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);

`ifdef SHIFTERS_SRA_EN
    localparam logic [5:0] SRA = 6'b000011;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_work;
    logic [SHAMT_W-1:0]  r_amt;
    logic                r_ok;
    logic [2:0]          r_cnt;
    logic                w_fill;
    logic                w_ok_in;
    logic [DATA_W-1:0]   w_stage;

`ifdef SHIFTERS_SRA_EN
    logic                r_fill;
    logic                w_fill_in;

    // Request validation and sign-fill selection at acceptance.
    always_comb begin
        w_ok_in   = ((Signal == SRL) || (Signal == SRA)) && (dataB[31:5] == 27'd0);
        if (Signal == SRA) begin
            w_fill_in = dataA[31];
        end else begin
            w_fill_in = 1'b0;
        end
    end

    assign w_fill = r_fill;

    // Fill bit is latched once per operation so later dataA changes cannot leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_fill <= w_fill_in;
        end else begin
            r_fill <= r_fill;
        end
    end
`else
    // Request validation at acceptance; only SRL with an amount below 32 is valid.
    always_comb begin
        w_ok_in = (Signal == SRL) && (dataB[31:5] == 27'd0);
    end

    assign w_fill = 1'b0;
`endif

    // One shift stage: the counter selects the stage size and amount bit.
    always_comb begin
        w_stage = r_work;
        case (r_cnt)
            3'd0: begin
                if (r_amt[0]) begin
                    w_stage = {{1{w_fill}}, r_work[31:1]};
                end else begin
                    w_stage = r_work;
                end
            end
            3'd1: begin
                if (r_amt[1]) begin
                    w_stage = {{2{w_fill}}, r_work[31:2]};
                end else begin
                    w_stage = r_work;
                end
            end
            3'd2: begin
                if (r_amt[2]) begin
                    w_stage = {{4{w_fill}}, r_work[31:4]};
                end else begin
                    w_stage = r_work;
                end
            end
            3'd3: begin
                if (r_amt[3]) begin
                    w_stage = {{8{w_fill}}, r_work[31:8]};
                end else begin
                    w_stage = r_work;
                end
            end
            3'd4: begin
                if (r_amt[4]) begin
                    w_stage = {{16{w_fill}}, r_work[31:16]};
                end else begin
                    w_stage = r_work;
                end
            end
            default: begin
                w_stage = r_work;
            end
        endcase
    end

    // Control FSM: accepts a request in IDLE, runs five stages, then publishes the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= 32'd0;
            r_amt   <= 5'd0;
            r_ok    <= 1'b0;
            r_cnt   <= 3'd0;
            dataOut <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // done is a single-cycle pulse; it always drops out of IDLE.
                    done <= 1'b0;
                    if (start) begin
                        r_work  <= dataA;
                        r_amt   <= dataB[SHAMT_W-1:0];
                        r_ok    <= w_ok_in;
                        r_cnt   <= 3'd0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_stage;
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'd4) begin
                        // Invalid requests still run the full latency and return 0.
                        if (r_ok) begin
                            dataOut <= w_stage;
                        end else begin
                            dataOut <= 32'd0;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
